// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - command/response streams and Wishbone classic bus bundle
interface wb_cmd_master_if #(
   parameter int AW = 3,
   parameter int DW = 32
);
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic          cmd_we_i;
   logic [AW-1:0] cmd_adr_i;
   logic [DW-1:0] cmd_dat_i;
   logic          resp_valid_o;
   logic          resp_ready_i;
   logic [DW-1:0] resp_dat_o;
   logic          resp_err_o;
   logic          cyc_o;
   logic          stb_o;
   logic          we_o;
   logic [AW-1:0] adr_o;
   logic [DW-1:0] dat_o;
   logic [DW-1:0] dat_i;
   logic          ack_i;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, resp_ready_i, dat_i, ack_i,
      output cmd_ready_o, resp_valid_o, resp_dat_o, resp_err_o,
             cyc_o, stb_o, we_o, adr_o, dat_o
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, resp_ready_i, dat_i, ack_i,
      input  cmd_ready_o, resp_valid_o, resp_dat_o, resp_err_o,
             cyc_o, stb_o, we_o, adr_o, dat_o
   );
endinterface

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-transfer initiator with timeout
module wb_cmd_master #(
   parameter int AW      = 3,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             wb_clk_i,
   input  logic             rst_i,
   wb_cmd_master_if.master  bus,
   output logic [7:0]       err_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Counter value seen during the TIMEOUT-th strobe cycle (counter starts at 0).
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t        state_q;
   logic          cyc_q;
   logic          stb_q;
   logic          we_q;
   logic [AW-1:0] adr_q;
   logic [DW-1:0] dat_q;
   logic          resp_valid_q;
   logic [DW-1:0] resp_dat_q;
   logic          resp_err_q;
   logic [7:0]    err_cnt_q;
   logic [15:0]   tmo_cnt_q;

   // Command acceptance, bus cycle with timeout, and response hand-off.
   always_ff @(posedge wb_clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         dat_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_dat_q   <= '0;
         resp_err_q   <= 1'b0;
         err_cnt_q    <= 8'd0;
         tmo_cnt_q    <= 16'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid_i) begin
                  we_q      <= bus.cmd_we_i;
                  adr_q     <= bus.cmd_adr_i;
                  dat_q     <= bus.cmd_dat_i;
                  cyc_q     <= 1'b1;
                  stb_q     <= 1'b1;
                  tmo_cnt_q <= 16'd0;
                  state_q   <= S_BUS;
               end
            end
            S_BUS: begin
               // ack takes priority over the timeout boundary on the same cycle
               if (bus.ack_i) begin
                  cyc_q        <= 1'b0;
                  stb_q        <= 1'b0;
                  resp_dat_q   <= we_q ? '0 : bus.dat_i;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  cyc_q        <= 1'b0;
                  stb_q        <= 1'b0;
                  resp_dat_q   <= '0;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= 1'b1;
                  if (err_cnt_q != 8'hFF) begin
                     err_cnt_q <= err_cnt_q + 8'd1;
                  end
                  tmo_cnt_q    <= tmo_cnt_q + 16'd1;
                  state_q      <= S_RESP;
               end else begin
                  tmo_cnt_q    <= tmo_cnt_q + 16'd1;
               end
            end
            S_RESP: begin
               if (bus.resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready_o  = (state_q == S_IDLE);
   assign bus.resp_valid_o = resp_valid_q;
   assign bus.resp_dat_o   = resp_dat_q;
   assign bus.resp_err_o   = resp_err_q;
   assign bus.cyc_o        = cyc_q;
   assign bus.stb_o        = stb_q;
   assign bus.we_o         = we_q;
   assign bus.adr_o        = adr_q;
   assign bus.dat_o        = dat_q;
   assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

   localparam int AW    = 3;
   localparam int DW    = 32;
   localparam int TMO   = 4;
   localparam int NEVER = 1000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] err_cnt;

   always #5 clk = ~clk;

   wb_cmd_master_if #(.AW(AW), .DW(DW)) bus ();

   wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .wb_clk_i  (clk),
      .rst_i     (rst),
      .bus       (bus),
      .err_cnt_o (err_cnt)
   );

   // Slave: acks after ack_delay wait cycles, combinationally from stb_o.
   int          stb_seen = 0;
   int          ack_delay = NEVER;
   logic        ack_force = 1'b0;
   logic [31:0] slave_rdata = 32'h0;

   always @(posedge clk) begin
      if (bus.stb_o) stb_seen <= stb_seen + 1;
      else           stb_seen <= 0;
   end

   assign bus.ack_i = ack_force | (bus.stb_o & (stb_seen == ack_delay));
   assign bus.dat_i = slave_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   int model_errs = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a command at a negedge while idle; returns at the negedge after acceptance.
   task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input int delay, input logic [DW-1:0] rdata);
      ack_delay   = delay;
      slave_rdata = rdata;
      check("cmd_ready_idle", bus.cmd_ready_o, 1);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = we;
      bus.cmd_adr_i   = adr;
      bus.cmd_dat_i   = dat;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      bus.cmd_dat_i   = ~dat;
      check("cmd_ready_busy", bus.cmd_ready_o, 0);
      check("cyc_start", bus.cyc_o, 1);
      check("stb_start", bus.stb_o, 1);
      check("we_o", bus.we_o, we);
      check("adr_o", bus.adr_o, adr);
      check("dat_o", bus.dat_o, dat);
   endtask

   // Observe the bus phase and compare the response against the reference rules.
   task automatic wait_resp(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input int delay, input logic [DW-1:0] rdata);
      int   stbs = 0;
      int   lat = 1;
      int   guard = 0;
      logic stable = 1'b1;
      int   exp_stb;
      logic exp_err;
      logic [DW-1:0] exp_dat;
      exp_err = (delay >= TMO);
      exp_stb = exp_err ? TMO : delay + 1;
      exp_dat = (exp_err || we) ? '0 : rdata;
      if (exp_err && model_errs < 255) model_errs++;
      while (!bus.resp_valid_o && guard < 100) begin
         if (bus.stb_o) stbs++;
         if (bus.we_o !== we || bus.adr_o !== adr || bus.dat_o !== dat) stable = 1'b0;
         @(negedge clk);
         lat++;
         guard++;
      end
      check("resp_wait_bound", guard < 100, 1);
      check("bus_stable", stable, 1);
      check("stb_cycles", stbs, exp_stb);
      check("resp_latency", lat, exp_stb + 1);
      check("stb_dropped", bus.stb_o, 0);
      check("cyc_dropped", bus.cyc_o, 0);
      check("resp_dat", bus.resp_dat_o, exp_dat);
      check("resp_err", bus.resp_err_o, exp_err);
      check("err_cnt", err_cnt, model_errs);
   endtask

   task automatic hold_release(input int hold);
      logic [DW-1:0] d0;
      logic          e0;
      d0 = bus.resp_dat_o;
      e0 = bus.resp_err_o;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", bus.resp_valid_o, 1);
         check("hold_dat", bus.resp_dat_o, d0);
         check("hold_err", bus.resp_err_o, e0);
         check("hold_cmd_ready", bus.cmd_ready_o, 0);
      end
      bus.resp_ready_i = 1'b1;
      @(negedge clk);
      bus.resp_ready_i = 1'b0;
      check("rel_valid", bus.resp_valid_o, 0);
      check("rel_cmd_ready", bus.cmd_ready_o, 1);
   endtask

   task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input int delay, input logic [DW-1:0] rdata, input int hold);
      issue(we, adr, dat, delay, rdata);
      wait_resp(we, adr, dat, delay, rdata);
      hold_release(hold);
   endtask

   initial begin
      logic          r_we;
      logic [AW-1:0] r_adr;
      logic [DW-1:0] r_dat;
      logic [DW-1:0] r_rd;

      rst              = 1'b1;
      bus.cmd_valid_i  = 1'b0;
      bus.cmd_we_i     = 1'b0;
      bus.cmd_adr_i    = '0;
      bus.cmd_dat_i    = '0;
      bus.resp_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_cmd_ready", bus.cmd_ready_o, 1);
      check("rst_resp_valid", bus.resp_valid_o, 0);
      check("rst_resp_err", bus.resp_err_o, 0);
      check("rst_resp_dat", bus.resp_dat_o, 0);
      check("rst_cyc", bus.cyc_o, 0);
      check("rst_stb", bus.stb_o, 0);
      check("rst_we", bus.we_o, 0);
      check("rst_adr", bus.adr_o, 0);
      check("rst_dat", bus.dat_o, 0);
      check("rst_err_cnt", err_cnt, 0);

      // zero-wait write
      run_txn(1'b1, 3'd0, 32'h0000_0100, 0, 32'hDEAD_BEEF, 0);
      // read with three wait cycles
      run_txn(1'b0, 3'd5, 32'h0, 3, 32'h1234_5678, 0);
      // timeout
      run_txn(1'b0, 3'd2, 32'h0, NEVER, 32'hAAAA_5555, 0);
      check("err_cnt_after_timeout", err_cnt, 1);
      // ack on the last allowed strobe cycle
      run_txn(1'b0, 3'd7, 32'h0, TMO - 1, 32'hCAFE_F00D, 0);
      check("err_cnt_boundary", err_cnt, 1);

      // ack while idle must not create a response
      ack_force = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_ack_resp", bus.resp_valid_o, 0);
         check("idle_ack_cyc", bus.cyc_o, 0);
      end
      ack_force = 1'b0;
      @(negedge clk);

      // response backpressure with a pending command
      issue(1'b0, 3'd3, 32'h0, 1, 32'h0BAD_CAFE);
      wait_resp(1'b0, 3'd3, 32'h0, 1, 32'h0BAD_CAFE);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = 1'b1;
      bus.cmd_adr_i   = 3'd6;
      bus.cmd_dat_i   = 32'h5A5A_0001;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", bus.resp_valid_o, 1);
         check("bp_dat", bus.resp_dat_o, 32'h0BAD_CAFE);
         check("bp_cmd_ready", bus.cmd_ready_o, 0);
         check("bp_stb", bus.stb_o, 0);
      end
      bus.resp_ready_i = 1'b1;
      @(negedge clk);
      bus.resp_ready_i = 1'b0;
      check("bp_rel_valid", bus.resp_valid_o, 0);
      check("bp_rel_cmd_ready", bus.cmd_ready_o, 1);
      check("bp_rel_stb", bus.stb_o, 0);
      ack_delay = 0;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      check("bp_next_stb", bus.stb_o, 1);
      check("bp_next_adr", bus.adr_o, 3'd6);
      wait_resp(1'b1, 3'd6, 32'h5A5A_0001, 0, 32'h0);
      hold_release(0);

      // randomized transfers
      for (int t = 0; t < 30; t++) begin
         r_we  = 1'($urandom_range(0, 1));
         r_adr = AW'($urandom);
         r_dat = $urandom;
         r_rd  = $urandom;
         run_txn(r_we, r_adr, r_dat, int'($urandom_range(0, TMO + 1)), r_rd,
                 int'($urandom_range(0, 3)));
      end

      // reset in the middle of a bus cycle
      issue(1'b0, 3'd1, 32'h0, NEVER, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_errs = 0;
      check("mid_rst_cyc", bus.cyc_o, 0);
      check("mid_rst_stb", bus.stb_o, 0);
      check("mid_rst_resp", bus.resp_valid_o, 0);
      check("mid_rst_cmd_ready", bus.cmd_ready_o, 1);
      check("mid_rst_err_cnt", err_cnt, 0);
      repeat (5) begin
         @(negedge clk);
         check("post_rst_no_resp", bus.resp_valid_o, 0);
      end

      // saturate the error counter
      for (int t = 0; t < 300; t++) begin
         run_txn(1'b0, AW'(t), 32'h0, NEVER, 32'h0, 0);
      end
      check("err_cnt_saturated", err_cnt, 8'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
